bnn_neuron_array: RTL
=====================

Name: bnn_neuron_array

Overview:
- Next-generation binary neuron processor: NUM_NEURONS XNOR-popcount neurons share one broadcast activation stream. Each neuron has its own weight lane and threshold.
- Accumulates over a multi-beat frame and supports partial last beats via a lane-keep mask.
- Emits one result word per frame (activation bit plus optional raw popcount per neuron) with a valid/ready output handshake and full-pipeline backpressure.
- Sits between the activation/weight fetch logic and the next layer's input buffer in the fully-connected BNN datapath.

Parameters:
- PARALLEL_INPUTS, 8, activation/weight bits consumed per beat (>=1).
- NUM_NEURONS, 4, neurons evaluated in parallel (>=1).
- COUNT_WIDTH, 16, popcount accumulator and threshold width per neuron.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  beat is the final beat of the frame.
- x  in  PARALLEL_INPUTS  broadcast activation bits.
- x_keep  in  PARALLEL_INPUTS  lane enable; 0 lanes contribute nothing to any count.
- w  in  NUM_NEURONS*PARALLEL_INPUTS  weights; neuron n uses slice [n*PI +: PI].
- threshold  in  NUM_NEURONS*COUNT_WIDTH  per-neuron threshold, sampled on the accepted last beat.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result.
- out_bits  out  NUM_NEURONS  bit n = (count_n >= threshold_n), unsigned compare.
- popcount  out  NUM_NEURONS*COUNT_WIDTH  final per-neuron counts (see Optional Feature).

Behaviour:
- Global stall: advance = !out_valid || out_ready; in_ready = advance. Beat accepted iff in_valid && in_ready.
- Every pipeline register updates only when advance=1. When advance=0, all state holds, including an in-flight stage-1 beat.
- Stage 1 (on accept): m_n = (x ~^ w_n) & x_keep registered; last and threshold captured. Bubble (no accept, advance=1): stage-1 valid clears.
- Stage 2 (stage-1 valid, advance=1):
  - sum_n = acc_n + popcount(m_n), saturating at 2^COUNT_WIDTH-1 (never wraps).
  - If stage-1 last: result register loads sum_n and out_bits_n = (sum_n >= thr_n), out_valid sets, acc_n clears to 0 in the same cycle.
  - Otherwise acc_n <= sum_n.
- Frame state, two states:
  - IDLE (acc all 0, no frame open) -> ACCUM on the first accepted non-last beat.
  - ACCUM -> IDLE when the last beat retires in stage 2.
  - A one-beat frame (first beat has in_last=1) stays in IDLE.
- Latency: last beat accepted at cycle t -> out_valid=1 at t+2 when unstalled.
- out_valid stays 1 with stable outputs until out_ready. Handshake cycle: out_valid drops unless a new last beat retires that same cycle, in which case out_valid stays 1 with the new data. Back-to-back frames are sustained at 1 beat/cycle.
- Beats of frame k+1 may be accepted while frame k's result is being handed off. The accumulator never mixes frames.
- x_keep all-zero beat: legal, adds 0 to every count.
- threshold=0: out_bits_n=1 for every frame.
- Reset (any time, mid-frame included), values after the reset edge:
  - out_valid=0, out_bits=0, popcount=0, all accumulators and stage-1 registers 0, state IDLE, in_ready=1.
  - A partial frame in flight is discarded.

Optional Feature:
- Macro BNN_POPCOUNT_OUT_EN.
- Defined: popcount port carries the registered final sums (saturated), updated together with out_bits.
- Undefined: popcount driven constant 0; no result-count register is implemented, and only the compare bits are stored.
- out_bits, timing and handshake are identical in both builds.

Test Plan:
- PI=8, N=2, thr={5,6}, one-beat frame x=8'hF0, w0=8'hF0, w1=8'h0F, keep=8'hFF, out_ready=1 -> out_valid at t+2; popcount={8,0}, out_bits=2'b01.
- 3-beat frame, x=w0=8'hFF each beat, keep=8'hFF,8'hFF,8'h0F, thr0=20 -> count0=20, out_bits[0]=1; rerun with thr0=21 -> out_bits[0]=0.
- out_ready held 0 for 5 cycles after out_valid while in_valid=1 continuously -> in_ready=0, result stable for 5 cycles; after release, next frame's result arrives with no beat lost or duplicated.
- Two back-to-back one-beat frames with out_ready=1, counts 3 then 7 -> out_valid high 2 consecutive cycles, popcount 3 then 7.
- COUNT_WIDTH=4, PI=8, 3 beats all-match -> popcount saturates at 15, not wrap to 8; out_bits=1 for thr=15.
- rst pulsed after 2 of 4 beats of a frame, then a new one-beat frame with count 2 -> popcount=2 (no residue); outputs 0 during and right after reset.

Source files
------------

// File: rtl/bnn_neuron_array.sv
// XNOR-popcount neuron array: broadcast activations, per-neuron weights and thresholds,
// two-stage pipeline with global stall. Define BNN_POPCOUNT_OUT_EN to expose final counts.
module bnn_neuron_array #(
    parameter int PARALLEL_INPUTS = 8,
    parameter int NUM_NEURONS     = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_last,
    input  logic [PARALLEL_INPUTS-1:0]         x,
    input  logic [PARALLEL_INPUTS-1:0]         x_keep,
    input  logic [NUM_NEURONS*PARALLEL_INPUTS-1:0] w,
    input  logic [NUM_NEURONS*COUNT_WIDTH-1:0] threshold,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_NEURONS-1:0]             out_bits,
    output logic [NUM_NEURONS*COUNT_WIDTH-1:0] popcount
);
    localparam int PI  = PARALLEL_INPUTS;
    localparam int N   = NUM_NEURONS;
    localparam int CW  = COUNT_WIDTH;
    localparam int PCW = $clog2(PI + 1);
    localparam int SW  = ((CW > PCW) ? CW : PCW) + 1;
    localparam logic [CW-1:0] MAXV = '1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state;
    logic              advance;
    logic              accept;
    logic              s1_valid;
    logic              s1_last;
    logic [N*PI-1:0]   s1_m;
    logic [N*CW-1:0]   s1_thr;
    logic [N*PI-1:0]   mask;
    logic [N*CW-1:0]   acc;
    logic [N*CW-1:0]   sum;
    logic [N-1:0]      hit;

    function automatic logic [PCW-1:0] ones(input logic [PI-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < PI; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    always_comb begin
        mask = '0;
        for (int unsigned n = 0; n < N; n++) begin
            mask[n*PI +: PI] = ~(x ^ w[n*PI +: PI]) & x_keep;
        end
    end

    // Sum is formed one bit wider than the accumulator so saturation can be detected.
    always_comb begin
        logic [SW-1:0] wide;
        wide = '0;
        sum  = '0;
        hit  = '0;
        for (int unsigned n = 0; n < N; n++) begin
            wide = SW'(acc[n*CW +: CW]) + SW'(ones(s1_m[n*PI +: PI]));
            if (wide > SW'(MAXV)) begin
                sum[n*CW +: CW] = MAXV;
            end else begin
                sum[n*CW +: CW] = wide[CW-1:0];
            end
            hit[n] = sum[n*CW +: CW] >= s1_thr[n*CW +: CW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_m      <= '0;
            s1_thr    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_bits  <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_m    <= mask;
                s1_last <= in_last;
                s1_thr  <= threshold;
            end
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    out_bits <= hit;
                    acc      <= '0;
                end else begin
                    acc <= sum;
                end
            end
            case (state)
                IDLE: begin
                    if (accept && !in_last) state <= ACCUM;
                end
                ACCUM: begin
                    if (s1_valid && s1_last) state <= (accept && !in_last) ? ACCUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BNN_POPCOUNT_OUT_EN
    logic [N*CW-1:0] pop_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_r <= '0;
        end else if (advance && s1_valid && s1_last) begin
            pop_r <= sum;
        end
    end

    assign popcount = pop_r;
`else
    assign popcount = '0;
`endif

endmodule
